uart_tx_fifo_drain: RTL and testbench

Read-side consumer for syn_fifo. It pops one word at a time from the FIFO read port (rd_en/rdata/empty) and serializes it as an asynchronous UART frame on a single line: start bit, data bits LSB first, optional parity, stop bit(s). It sits directly downstream of the transmit FIFO, so bursts written by the host drain at line rate. It never reads an empty FIFO, so the FIFO's underflow flag must stay 0 in normal operation.

---
 rtl/uart_tx_fifo_drain_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_tx_fifo_drain.sv | 141 ++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types for the FIFO-draining UART transmitter: FSM state encoding and parity helpers.
package uart_tx_fifo_drain_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_e;

    localparam logic PARITY_RST = 1'b0;

    // Even parity is the plain XOR of the data; odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic odd);
        return data_xor ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time down-counter: reloads to CLKS_PER_BIT-1 on load and flags the last cycle of a bit.
module uart_baud_cnt
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic res,
    input  logic load,
    output logic bit_end
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CNT_WIDTH'(CLKS_PER_BIT - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from a synchronous FIFO one at a time and serializes each as a UART frame
// (start, data LSB first, optional parity, 1 or 2 stop bits).
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [IDX_W-1:0]   r_bit_idx;
    logic               r_parity;
    logic               r_stop_idx;
    logic               r_tx;
    logic               r_rd_en;
    logic               r_busy;
    logic               r_frame_done;
    logic               w_bit_end;
    logic               w_baud_load;

    // Restart the bit timer when leaving LOAD and at every bit boundary on the line.
    assign w_baud_load = (r_state == ST_LOAD) ||
                         (w_bit_end && (r_state == ST_START || r_state == ST_DATA ||
                                        r_state == ST_PARITY || r_state == ST_STOP));

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud (
        .clk     (clk),
        .res     (res),
        .load    (w_baud_load),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_parity     <= PARITY_RST;
            r_stop_idx   <= 1'b0;
            r_tx         <= 1'b1;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        r_state <= ST_FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                // FIFO read data is valid here, one cycle after the read strobe.
                ST_LOAD: begin
                    r_shift  <= fifo_rdata;
                    r_parity <= parity_bit(^fifo_rdata, 1'(PARITY_ODD));
                    r_tx     <= 1'b0;
                    r_state  <= ST_START;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == IDX_W'(WIDTH - 1)) begin
                            r_stop_idx <= 1'b0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: two configurations (8N1 and 8O2), each fed by a FIFO model
// and checked by a line-level UART receiver against a queue of expected words.
module tb_uart_tx_fifo_drain;

    localparam int unsigned W   = 8;
    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int unsigned PE    = (g == 1) ? 1 : 0;
        localparam int unsigned PO    = (g == 1) ? 1 : 0;
        localparam int unsigned SB    = (g == 1) ? 2 : 1;
        localparam int unsigned NBITS = 1 + W + PE + SB;
        localparam int unsigned FRAME = NBITS * CPB;
        localparam logic [W-1:0] FIRST = (g == 1) ? 8'h03 : 8'hA5;

        logic         res;
        logic         enable;
        logic         fifo_empty;
        logic [W-1:0] rdata = '0;
        logic         rd_en;
        logic         tx;
        logic         busy;
        logic         frame_done;

        logic [W-1:0] fq[$];
        logic [W-1:0] exp_q[$];
        logic underflow = 1'b0;
        logic double_rd = 1'b0;
        logic rd_prev   = 1'b0;
        int   n_rd      = 0;
        int   n_fd      = 0;
        int   busy_cnt  = 0;
        int   cyc       = 0;
        int   n_pushed  = 0;
        int   n_frames  = 0;

        uart_tx_fifo_drain #(
            .WIDTH        (W),
            .CLKS_PER_BIT (CPB),
            .STOP_BITS    (SB),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO)
        ) dut (
            .clk        (clk),
            .res        (res),
            .enable     (enable),
            .fifo_empty (fifo_empty),
            .fifo_rdata (rdata),
            .fifo_rd_en (rd_en),
            .tx         (tx),
            .busy       (busy),
            .frame_done (frame_done)
        );

        // FIFO model: registered read data, one word per strobe.
        assign fifo_empty = (fq.size() == 0);

        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (rd_en === 1'b1) begin
                n_rd <= n_rd + 1;
                if (fq.size() == 0) underflow <= 1'b1;
                else rdata <= fq.pop_front();
                if (rd_prev) double_rd <= 1'b1;
            end
            rd_prev <= (rd_en === 1'b1);
            if (frame_done === 1'b1) n_fd <= n_fd + 1;
            if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        end

        task automatic push(input logic [W-1:0] b);
            fq.push_back(b);
            exp_q.push_back(b);
            n_pushed++;
        endtask

        task automatic wait_quiet();
            int q = 0;
            int k = 0;
            while (q < 8 && k < 6000) begin
                @(negedge clk);
                k++;
                if (busy === 1'b0 && fq.size() == 0 && tx === 1'b1) q++;
                else q = 0;
            end
            check("drain_done", 32'(q >= 8), 1);
        endtask

        task automatic wait_rd();
            int k = 0;
            logic seen = 1'b0;
            while (!seen && k < 200) begin
                @(negedge clk);
                k++;
                seen = (rd_en === 1'b1);
            end
            check("fetch_seen", 32'(seen), 1);
        endtask

        task automatic wait_idle();
            int k = 0;
            logic idle = 1'b0;
            while (!idle && k < 200) begin
                @(negedge clk);
                k++;
                idle = (busy === 1'b0);
            end
            check("idle_reached", 32'(idle), 1);
        endtask

        // Line receiver: captures each frame cycle by cycle and compares it to the next expected word.
        initial begin : mon
            logic             smp [FRAME];
            logic [NBITS-1:0] bits;
            logic [NBITS-1:0] exp_bits;
            logic [W-1:0]     exp_d;
            logic             aborted;
            logic             expect_gap;
            int               rd_cyc;
            int               last_end;
            int               bad_w;
            rd_cyc     = -100;
            last_end   = -100;
            expect_gap = 1'b0;
            forever begin
                @(negedge clk);
                if (res !== 1'b0) begin
                    expect_gap = 1'b0;
                    continue;
                end
                if (rd_en === 1'b1) rd_cyc = cyc;
                if (tx !== 1'b0) continue;
                check("start_latency", cyc - rd_cyc, 2);
                if (expect_gap) check("frame_gap", cyc - last_end, 3);
                expect_gap = 1'b0;
                smp[0]  = tx;
                aborted = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (res !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[k] = tx;
                end
                if (aborted) continue;
                @(negedge clk);
                if (res !== 1'b0) continue;
                check("frame_done", 32'(frame_done), 1);
                bad_w = 0;
                for (int b = 0; b < NBITS; b++) begin
                    bits[b] = smp[b*CPB];
                    for (int s = 1; s < CPB; s++)
                        if (smp[b*CPB+s] !== bits[b]) bad_w++;
                end
                check("bit_width", bad_w, 0);
                check("frame_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_d            = exp_q.pop_front();
                    exp_bits         = '1;
                    exp_bits[0]      = 1'b0;
                    exp_bits[W:1]    = exp_d;
                    exp_bits[W+1]    = (PE != 0) ? ((^exp_d) ^ 1'(PO)) : 1'b1;
                    check("frame_bits", 32'(bits), 32'(exp_bits));
                end
                n_frames++;
                last_end   = cyc;
                expect_gap = (enable === 1'b1) && (fifo_empty === 1'b0);
            end
        end

        initial begin : stim
            int rd0;
            int b0;
            int tl;
            res    = 1'b1;
            enable = 1'b1;
            push(FIRST);
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check("reset_hold", 32'({tx, rd_en, busy, frame_done}), 32'(4'b1000));
            end
            b0  = busy_cnt;
            rd0 = n_rd;
            res = 1'b0;
            wait_quiet();
            check("single_busy", busy_cnt - b0, 2 + FRAME);
            check("single_rd", n_rd - rd0, 1);

            rd0 = n_rd;
            tl  = 0;
            repeat (100) begin
                @(negedge clk);
                if (tx !== 1'b1) tl++;
            end
            check("empty_rd", n_rd - rd0, 0);
            check("empty_tx_low", tl, 0);
            check("empty_underflow", 32'(underflow), 0);

            rd0 = n_rd;
            @(posedge clk); #1;
            push(8'h00);
            push(8'hFF);
            push(8'h55);
            wait_quiet();
            check("burst_rd", n_rd - rd0, 3);
            check("burst_empty", 32'(fifo_empty), 1);

            repeat (600) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 24) == 0) push(W'($urandom));
                if ($urandom_range(0, 59) == 0) enable = ~enable;
            end
            enable = 1'b1;
            wait_quiet();

            rd0 = n_rd;
            @(posedge clk); #1;
            push(W'($urandom));
            push(W'($urandom));
            wait_rd();
            repeat (19) @(posedge clk);
            #1 enable = 1'b0;
            wait_idle();
            repeat (80) @(posedge clk);
            #1;
            check("hold_rd", n_rd - rd0, 1);
            check("hold_left", fq.size(), 1);
            enable = 1'b1;
            wait_quiet();

            rd0 = n_rd;
            @(posedge clk); #1;
            push(W'($urandom));
            push(W'($urandom));
            wait_rd();
            repeat (19) @(posedge clk);
            #1 res = 1'b1;
            void'(exp_q.pop_front());
            @(posedge clk); #1;
            res = 1'b0;
            @(negedge clk);
            check("reset_tx", 32'(tx), 1);
            wait_quiet();
            check("reset_rd", n_rd - rd0, 2);

            repeat (5) @(posedge clk);
            #1;
            check("exp_left", exp_q.size(), 0);
            check("rd_total", n_rd, n_pushed);
            check("fd_total", n_fd, n_frames);
            check("underflow", 32'(underflow), 0);
            check("double_rd", 32'(double_rd), 0);
            n_done++;
        end
    end

    initial begin
        wait (n_done == 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (40000) @(posedge clk);
        n_bad++;
        $display("FAIL watchdog: got %0d finished configs, expected 2", n_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "bench did not complete");
    end

endmodule
